// File: rtl/gen_ctrl_if.sv
// Start/stop/config bus from the control logic plus the phase-counter
// link (value in, enable out) and the waveform/status outputs of gen_ctrl.
interface gen_ctrl_if #(
  parameter int DIV_W = 16
);
  logic             start;
  logic             stop;
  logic [1:0]       mode;
  logic [DIV_W-1:0] div;
  logic [7:0]       cnt_q;
  logic             cnt_en;
  logic [7:0]       wave;
  logic             wrap;
  logic             busy;
  logic [1:0]       state;

  modport master (
    output start, stop, mode, div, cnt_q,
    input  cnt_en, wave, wrap, busy, state
  );

  modport slave (
    input  start, stop, mode, div, cnt_q,
    output cnt_en, wave, wrap, busy, state
  );
endinterface

// File: rtl/gen_ctrl.sv
// Sequencing controller for the unresettable 8-bit phase counter: homes it to
// zero, paces it with a prescaler, stops at end of period and shapes the wave.
module gen_ctrl #(
  parameter int DIV_W = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  gen_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOME     = 2'd1,
    RUN      = 2'd2,
    STOPPING = 2'd3
  } state_t;

  localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic             stop_pend_q, stop_pend_d;
  logic [1:0]       mode_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] pre_q;
  logic [7:0]       wave_p1;
  logic             wrap_p1;

  logic             cnt_en;
  logic             running;
  logic             run_next;
  logic             at_top;
  logic             accept;
  logic [1:0]       mode_sel;
  logic [DIV_W-1:0] div_sel;

  function automatic logic [7:0] shape(input logic [7:0] q, input logic [1:0] m);
    logic [7:0] r;
    case (m)
      2'd0:    r = q;
      2'd1:    r = q[7] ? ~{q[6:0], 1'b0} : {q[6:0], 1'b0};
      2'd2:    r = q[7] ? 8'hFF : 8'h00;
      default: r = ~q;
    endcase
    return r;
  endfunction

  always_comb begin
    running  = (state_q == RUN) || (state_q == STOPPING);
    run_next = (state_d == RUN) || (state_d == STOPPING);
    at_top   = (bus.cnt_q == 8'hFF);
    accept   = (state_q == IDLE) && bus.start;
    // On the accepting edge the fresh config is used before it lands in the latches.
    mode_sel = accept ? bus.mode : mode_q;
    div_sel  = accept ? bus.div  : div_q;
  end

  always_comb begin
    cnt_en = 1'b0;
    case (state_q)
      IDLE:    cnt_en = 1'b0;
      HOME:    cnt_en = (bus.cnt_q != 8'd0);
      default: cnt_en = (pre_q == '0);
    endcase
  end

  always_comb begin
    state_d     = state_q;
    stop_pend_d = stop_pend_q;
    case (state_q)
      IDLE: begin
        stop_pend_d = 1'b0;
        if (bus.start) state_d = (bus.cnt_q != 8'd0) ? HOME : RUN;
      end
      HOME: begin
        if (bus.stop) stop_pend_d = 1'b1;
        if (bus.cnt_q == 8'd0) begin
          state_d     = (stop_pend_q || bus.stop) ? IDLE : RUN;
          stop_pend_d = 1'b0;
        end
      end
      RUN: begin
        if (bus.stop) state_d = STOPPING;
      end
      STOPPING: begin
        if (cnt_en && at_top) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      stop_pend_q <= 1'b0;
      mode_q      <= 2'd0;
      div_q       <= '0;
      pre_q       <= '0;
    end else begin
      state_q     <= state_d;
      stop_pend_q <= stop_pend_d;
      if (accept) begin
        mode_q <= bus.mode;
        div_q  <= bus.div;
      end
      if ((state_d == RUN) && !running)
        pre_q <= div_sel;
      else if (running)
        pre_q <= (pre_q == '0) ? div_q : (pre_q - DIV_ONE);
    end
  end

  // Stage p1: registered waveform sample and wrap pulse, one clock behind cnt_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wave_p1 <= 8'd0;
      wrap_p1 <= 1'b0;
    end else begin
      wave_p1 <= run_next ? shape(bus.cnt_q, mode_sel) : 8'd0;
      wrap_p1 <= running && cnt_en && at_top;
    end
  end

  assign bus.cnt_en = cnt_en;
  assign bus.wave   = wave_p1;
  assign bus.wrap   = wrap_p1;
  assign bus.busy   = (state_q != IDLE);
  assign bus.state  = state_q;

endmodule

// File: doc/gen_ctrl.md
# gen_ctrl

Sequencing controller for the waveform generator's 8-bit free-running phase counter (`count_1`), which has no reset or clear. It homes the counter to zero, paces it through a programmable prescaler, and stops it cleanly at the end of a period. It also shapes the counter phase into the selected output waveform. It sits between the front-panel/control logic (start/stop/config) and the counter/DAC path.

## Interface
Parameters:
- `DIV_W`, 16: prescaler divisor width.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: level sampled each edge; begins generation from IDLE.
- `stop` input 1: level sampled each edge; requests a graceful stop at the end of the period.
- `mode` input 2: waveform select, latched on accepted start: 0 saw, 1 triangle, 2 square, 3 inverted saw.
- `div` input DIV_W: prescaler divisor, latched on accepted start; enable period is div+1 clocks.
- `cnt_q` input 8: current counter value from the phase counter.
- `cnt_en` output 1: enable to the phase counter. Combinational from registered state, prescaler and `cnt_q`.
- `wave` output 8: registered waveform sample.
- `wrap` output 1: registered one-cycle pulse; the counter has just wrapped 255→0 while running.
- `busy` output 1: registered; high in any state other than IDLE.
- `state` output 2: IDLE=0, HOME=1, RUN=2, STOPPING=3.

## Operation
- IDLE:
  - `cnt_en`=0 and `wave`=0.
  - `start`=1 latches `mode`/`div`. Next state is HOME if `cnt_q`≠0, otherwise RUN.
  - `stop` is ignored; `start` wins if both are high.
- HOME:
  - `cnt_en` = (`cnt_q`≠0).
  - At the edge where `cnt_q`==0, go to RUN, or to IDLE if a stop is pending.
  - `stop` in HOME sets `stop_pend`. No `wrap` pulses occur in HOME.
- RUN:
  - Prescaler `pre` is loaded with the latched div on entry.
  - `cnt_en`=1 exactly in cycles where `pre`==0. At that edge `pre` reloads div; otherwise it decrements.
  - `stop`=1 → STOPPING; the prescaler continues undisturbed. `start` is ignored, and `stop` wins if both are high.
- STOPPING:
  - Same pacing as RUN.
  - At the edge where `cnt_en`=1 and `cnt_q`==8'hFF, go to IDLE. The counter then rests at 0, so the next start skips HOME.
  - `start` and `stop` are ignored.
- `wrap`: set for one cycle following any edge in RUN/STOPPING with `cnt_en`=1 and `cnt_q`==8'hFF.
- `wave`, registered each cycle in RUN/STOPPING from `cnt_q`=q and the latched mode; 0 in IDLE/HOME:
  - saw: q.
  - triangle: q[7]=0 → {q[6:0],0}; q[7]=1 → ~{q[6:0],0}.
  - square: q[7] ? 8'hFF : 8'h00.
  - inverted saw: ~q.
- Configuration inputs changing outside an accepted start have no effect.

## Timing
- Reset (async assert, no clock needed):
  - state=IDLE, `cnt_en`=0, `wave`=0, `wrap`=0, `busy`=0, `stop_pend`=0, `pre`=0, latched mode=0, latched div=0.
  - The counter itself is not reset, so a start after a mid-run reset homes first.
- Start → `state`/`busy` update on the same edge; HOME/RUN is visible the next cycle.
- First RUN cycle is index 0. The first `cnt_en` occurs at index div; thereafter `cnt_en` repeats every div+1 cycles. div=0 gives `cnt_en` every cycle.
- `wave` lags `cnt_q` by exactly one clock.
- The HOME→RUN transition edge has `cnt_en`=0 (`cnt_q`==0).
- Full RUN period = 256×(div+1) clocks between consecutive `wrap` pulses.
- The final `wrap` from STOPPING coincides with the first IDLE cycle; `busy` falls in that cycle.

## Test plan
- Reset mid-RUN (`rst_n` low between edges) → `cnt_en`, `wave`, `busy`, `wrap`, `state` all 0 immediately; later start with `cnt_q`=37 → HOME, `cnt_en` high for 219 cycles, then RUN.
- `cnt_q`=0, start, mode=0, div=3 → RUN next cycle; `cnt_en` at RUN cycles 3, 7, 11, …; `wave` equals the previous cycle's `cnt_q`; `wrap` every 1024 clocks.
- `cnt_q`=250, start, div=0 → HOME with 6 `cnt_en` cycles, no `wrap`, RUN when `cnt_q`=0; `stop` during HOME → IDLE at `cnt_q`=0, never entering RUN.
- RUN, div=0, `stop` at `cnt_q`=10 → 246 more enables, one `wrap`, IDLE with `cnt_q`=0, `busy`=0; restart goes straight to RUN.
- Mode checks at `cnt_q` 0x40/0xC0/0x7F/0x80:
  - triangle → 0x80/0x7F/0xFE/0xFF.
  - square → 0x00/0xFF/0x00/0xFF.
  - inverted saw 0x40 → 0xBF.
- `start`+`stop` together in IDLE → starts; `start`+`stop` together in RUN → STOPPING; `div`/`mode` changed mid-RUN → no effect on pacing or `wave`.
